// File: rtl/stream_source_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_source_ctrl_if
// Brief    : Producer / buffer-write bundle for the stream source controller.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_source_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        start;
    logic                     stop;
    logic [CNT_W-1:0]         burst_len;
    logic [NUM_CH*DATA_W-1:0] src_data;
    logic [NUM_CH-1:0]        src_valid;
    logic [NUM_CH-1:0]        src_en;
    logic                     buf_full;
    logic                     buf_empty;
    logic                     rd_valid;
    logic                     wr_en;
    logic [DATA_W-1:0]        wr_data;
    logic [CH_W-1:0]          active_ch;
    logic [1:0]               state;
    logic [CNT_W-1:0]         word_cnt;
    logic                     done;

    modport master (
        input  start, stop, burst_len, src_data, src_valid,
               buf_full, buf_empty, rd_valid,
        output src_en, wr_en, wr_data, active_ch, state, word_cnt, done
    );

    modport slave (
        output start, stop, burst_len, src_data, src_valid,
               buf_full, buf_empty, rd_valid,
        input  src_en, wr_en, wr_data, active_ch, state, word_cnt, done
    );
endinterface
`default_nettype wire

// File: rtl/stream_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stream_source_ctrl
// Brief    : N-channel source selector streaming one producer into a buffer.
// Revision : 1.0 - initial release
// ============================================================================
module stream_source_ctrl #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    stream_source_ctrl_if.master bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_active_ch;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [CNT_W-1:0]    r_len_q;
    logic [NUM_CH-1:0]   r_start_q;
    logic                r_stop_q;

    logic [NUM_CH-1:0]   w_start_rise;
    logic                w_stop_rise;
    logic [CH_W-1:0]     w_start_idx;
    logic                w_launch;
    logic                w_burst_done;
    logic                w_sel_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic [DATA_W-1:0]   w_data_arr [NUM_CH];
    logic [NUM_CH-1:0]   w_src_en;
    logic                w_wr_en;
    logic                w_done;

    // Edge registers reset high so a button held through reset release stays silent
    assign w_start_rise = bus.start & ~r_start_q;
    assign w_stop_rise  = bus.stop & ~r_stop_q;
    assign w_launch     = (r_state == S_IDLE) && (|w_start_rise);
    assign w_burst_done = (r_len_q != '0) && (r_word_cnt == r_len_q);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            assign w_data_arr[k] = bus.src_data[k*DATA_W +: DATA_W];
            assign w_src_en[k]   = rst && (r_state == S_RUN) && (r_active_ch == CH_W'(k));
        end
    endgenerate

    always_comb begin
        w_start_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_start_rise[k]) begin
                w_start_idx = CH_W'(k);
            end
        end
    end

    assign w_sel_valid = bus.src_valid[r_active_ch];
    assign w_sel_data  = w_data_arr[r_active_ch];
    assign w_wr_en     = rst && (r_state == S_RUN) && w_sel_valid &&
                         !bus.buf_full && !w_burst_done;

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_stop_rise || w_burst_done) begin
                    w_state_nxt = S_DRAIN;
                end else if (bus.buf_full) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_stop_rise) begin
                    w_state_nxt = S_DRAIN;
                end else if (!bus.buf_full) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (bus.buf_empty && !bus.rd_valid) begin
                    w_state_nxt = S_IDLE;
                    w_done      = rst;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_active_ch <= '0;
            r_word_cnt  <= '0;
            r_len_q     <= '0;
            r_start_q   <= '1;
            r_stop_q    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= bus.start;
            r_stop_q  <= bus.stop;
            if (w_launch) begin
                r_active_ch <= w_start_idx;
                r_len_q     <= bus.burst_len;
                r_word_cnt  <= '0;
            end else if (w_wr_en && (r_word_cnt != {CNT_W{1'b1}})) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.src_en    = w_src_en;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_data   = (rst && (r_state == S_RUN)) ? w_sel_data : '0;
    assign bus.active_ch = r_active_ch;
    assign bus.state     = r_state;
    assign bus.word_cnt  = r_word_cnt;
    assign bus.done      = w_done;
endmodule
`default_nettype wire

// File: tb/tb_stream_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_source_ctrl
// Brief    : Directed self-checking bench for stream_source_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_source_ctrl;
    logic clk;
    logic rst;

    stream_source_ctrl_if #(.NUM_CH(2), .DATA_W(16), .CNT_W(16)) bus ();

    stream_source_ctrl #(.NUM_CH(2), .DATA_W(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors;
    int          checks;
    int          done_cnt;
    logic [15:0] wq[$];
    logic [15:0] fa, fb, tv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_src();
        bus.src_data = {tv, fa};
    endtask

    // Producers advance only when their word is actually written
    task automatic step();
        logic        adv0, adv1;
        logic [15:0] tmp;
        #1;
        adv0 = bus.wr_en && bus.src_en[0];
        adv1 = bus.wr_en && bus.src_en[1];
        if (bus.wr_en) wq.push_back(bus.wr_data);
        if (bus.done) done_cnt++;
        @(posedge clk);
        #1;
        if (adv0) begin
            tmp = fa + fb;
            fa  = fb;
            fb  = tmp;
        end
        if (adv1) tv = tv + 16'd1;
        load_src();
    endtask

    task automatic fib_reset();
        fa = 16'd0;
        fb = 16'd1;
        load_src();
    endtask

    logic [15:0] fib_exp [5];
    logic [15:0] obs_w;

    initial begin
        errors = 0; checks = 0; done_cnt = 0;
        fib_exp = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};
        rst = 1'b0;
        bus.start = 2'b01; bus.stop = 1'b0; bus.burst_len = 16'd0;
        bus.src_valid = 2'b00; bus.buf_full = 1'b0;
        bus.buf_empty = 1'b1; bus.rd_valid = 1'b0;
        tv = 16'd100;
        fib_reset();

        // 1: reset with start[0] held across release
        repeat (3) step();
        chk("rst_state", bus.state, 0);
        chk("rst_active", bus.active_ch, 0);
        chk("rst_wcnt", bus.word_cnt, 0);
        chk("rst_srcen", bus.src_en, 0);
        chk("rst_wren", bus.wr_en, 0);
        chk("rst_wrdata", bus.wr_data, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b1;
        step(); step();
        chk("held_start_idle", bus.state, 0);
        bus.start = 2'b00;
        bus.src_valid = 2'b11;
        step();
        chk("idle_no_wr", wq.size(), 0);

        // 2: continuous timer run stopped after 10 writes
        bus.buf_empty = 1'b0; bus.rd_valid = 1'b1; bus.burst_len = 16'd0;
        bus.start = 2'b10;
        step();
        chk("t2_state_run", bus.state, 1);
        chk("t2_active", bus.active_ch, 1);
        bus.start = 2'b00;
        #1;
        chk("t2_srcen", bus.src_en, 2'b10);
        chk("t2_wren", bus.wr_en, 1);
        chk("t2_wrdata0", bus.wr_data, 100);
        repeat (9) step();
        bus.stop = 1'b1;
        step();
        chk("t2_wcnt", bus.word_cnt, 10);
        chk("t2_state_drain", bus.state, 3);
        chk("t2_drain_srcen", bus.src_en, 0);
        chk("t2_drain_wren", bus.wr_en, 0);
        bus.stop = 1'b0;
        step();
        chk("t2_drain_hold", bus.state, 3);
        chk("t2_no_early_done", done_cnt, 0);
        bus.buf_empty = 1'b1; bus.rd_valid = 1'b0;
        #1;
        chk("t2_done_comb", bus.done, 1);
        step();
        chk("t2_idle", bus.state, 0);
        chk("t2_done_once", done_cnt, 1);
        chk("t2_wcnt_hold", bus.word_cnt, 10);
        chk("t2_nwr", wq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            obs_w = (i < wq.size()) ? wq[i] : 16'hxxxx;
            chk($sformatf("t2_wr%0d", i), obs_w, 100 + i);
        end

        // 3: burst of 5 fibonacci words with auto drain
        wq.delete(); done_cnt = 0; fib_reset();
        bus.buf_empty = 1'b0; bus.rd_valid = 1'b1; bus.burst_len = 16'd5;
        bus.start = 2'b01;
        step();
        chk("t3_state_run", bus.state, 1);
        chk("t3_active", bus.active_ch, 0);
        chk("t3_wcnt0", bus.word_cnt, 0);
        bus.start = 2'b00;
        repeat (5) step();
        chk("t3_wcnt5", bus.word_cnt, 5);
        chk("t3_still_run", bus.state, 1);
        chk("t3_no_6th_wr", bus.wr_en, 0);
        step();
        chk("t3_auto_drain", bus.state, 3);
        bus.buf_empty = 1'b1; bus.rd_valid = 1'b0;
        step();
        chk("t3_idle", bus.state, 0);
        chk("t3_done_once", done_cnt, 1);
        chk("t3_nwr", wq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            obs_w = (i < wq.size()) ? wq[i] : 16'hxxxx;
            chk($sformatf("t3_wr%0d", i), obs_w, fib_exp[i]);
        end

        // 4: back-pressure mid-run, then 6: reset while in WAIT
        wq.delete(); fib_reset();
        bus.buf_empty = 1'b0; bus.rd_valid = 1'b1; bus.burst_len = 16'd0;
        bus.start = 2'b01;
        step();
        bus.start = 2'b00;
        repeat (3) step();
        bus.buf_full = 1'b1;
        #1;
        chk("t4_full_wren", bus.wr_en, 0);
        chk("t4_full_srcen_run", bus.src_en, 2'b01);
        step();
        chk("t4_wait", bus.state, 2);
        chk("t4_wait_srcen", bus.src_en, 0);
        chk("t4_wait_wren", bus.wr_en, 0);
        repeat (3) step();
        chk("t4_wait_hold", bus.state, 2);
        chk("t4_wait_nwr", wq.size(), 3);
        bus.buf_full = 1'b0;
        step();
        chk("t4_resume", bus.state, 1);
        repeat (2) step();
        chk("t4_wcnt", bus.word_cnt, 5);
        chk("t4_nwr", wq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            obs_w = (i < wq.size()) ? wq[i] : 16'hxxxx;
            chk($sformatf("t4_wr%0d", i), obs_w, fib_exp[i]);
        end
        bus.buf_full = 1'b1;
        step();
        chk("t6_wait_again", bus.state, 2);
        rst = 1'b0;
        step();
        chk("t6_wait_rst_state", bus.state, 0);
        chk("t6_wait_rst_wcnt", bus.word_cnt, 0);
        chk("t6_wait_rst_srcen", bus.src_en, 0);
        rst = 1'b1;
        bus.buf_full = 1'b0;
        step();

        // 5: stop in IDLE ignored, simultaneous starts, start during RUN ignored
        bus.stop = 1'b1;
        step();
        chk("t5_stop_idle", bus.state, 0);
        bus.stop = 1'b0;
        step();
        wq.delete(); fib_reset();
        bus.start = 2'b11; bus.stop = 1'b1;
        step();
        chk("t5_start_wins", bus.state, 1);
        chk("t5_lowest_ch", bus.active_ch, 0);
        bus.start = 2'b01;
        step();
        bus.start = 2'b11;
        step();
        chk("t5_run_ignore_start", bus.state, 1);
        chk("t5_run_keep_ch", bus.active_ch, 0);
        chk("t5_run_srcen", bus.src_en, 2'b01);
        bus.stop = 1'b0;
        step();
        bus.stop = 1'b1;
        step();
        chk("t5_drain", bus.state, 3);
        chk("t5_wcnt_nonzero", (bus.word_cnt != 16'd0), 1);

        // 6: reset while in DRAIN
        rst = 1'b0;
        step();
        chk("t6_drain_rst_state", bus.state, 0);
        chk("t6_drain_rst_wcnt", bus.word_cnt, 0);
        chk("t6_drain_rst_srcen", bus.src_en, 0);
        rst = 1'b1;
        bus.stop = 1'b0; bus.start = 2'b00;
        step();
        chk("t6_idle_after", bus.state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
